imem_loader: RTL and testbench

- Boot-time program loader that drives the write port of the instruction memory.
- Receives a framed byte stream over a valid/ready handshake, typically from a UART RX block.
- Packs bytes into little-endian 32-bit words and writes them to consecutive word addresses from 0.
- Holds the core in reset while loading and releases it once a frame passes its checksum.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and frame layout constants for the program loader.
// Rev 1.0
`default_nettype none

package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 14;

  // Frame layout: 2 length bytes, 4 bytes per word, 1 trailing checksum byte
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_BYTES = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    FIN  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four consecutive bytes into a little-endian word, pulsing word_valid once per word.
// Rev 1.0
`default_nettype none

module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        clear,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= 2'd0;
      shreg      <= 24'd0;
      word_out   <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
      end else if (byte_valid) begin
        // Newest byte enters at the top so the first byte ends up in bits [7:0]
        shreg <= {byte_in, shreg[23:8]};
        lane  <= lane + 2'd1;
        if (lane == 2'(WORD_BYTES - 1)) begin
          word_out   <= {byte_in, shreg};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: receives a length/data/checksum framed byte stream and writes it into instruction memory.
// Rev 1.0
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_hold
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state;
  logic [15:0]       count;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   addr_cnt;
  logic [7:0]        csum;
  logic              accept;
  logic              last_word;
  logic [15:0]       len_full;

  assign rx_ready  = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, count[7:0]};
  // addr_cnt counts words already completed, so +1 includes the one finishing now
  assign last_word = (17'(addr_cnt) + 17'd1) == {1'b0, count};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (rx_data),
    .byte_valid (accept && (state == DATA)),
    .clear      (start && (state == IDLE)),
    .word_out   (mem_data),
    .word_valid (mem_wen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 16'd0;
      byte_idx  <= 2'd0;
      addr_cnt  <= '0;
      csum      <= 8'd0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      core_hold <= HOLD_AT_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LEN0;
            busy      <= 1'b1;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            csum      <= 8'd0;
            addr_cnt  <= '0;
            byte_idx  <= 2'd0;
          end
        end
        LEN0: begin
          if (accept) begin
            count[7:0] <= rx_data;
            csum       <= csum ^ rx_data;
            state      <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            count[15:8] <= rx_data;
            csum        <= csum ^ rx_data;
            if ({1'b0, len_full} > MAX_WORDS) begin
              err   <= 1'b1;
              state <= FIN;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_addr <= addr_cnt[ADDR_W-1:0];
              addr_cnt <= addr_cnt + {{ADDR_W{1'b0}}, 1'b1};
              if (last_word) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (rx_data == csum) done <= 1'b1;
            else                 err  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          state     <= IDLE;
          busy      <= 1'b0;
          core_hold <= !done;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked against a frame-level reference model.
// Rev 1.0
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 14;

  typedef logic [7:0]  byte_q[$];
  typedef logic [31:0] word_q[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    longint            t;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_hold;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  wr_t    wq[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .HOLD_AT_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .core_hold (core_hold)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_wen === 1'b1) wq.push_back('{mem_addr, mem_data, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: interprets a frame purely from the framing rules
  task automatic model(input byte_q f, output word_q w, output bit e_done, output bit e_err);
    int   n;
    logic [7:0] x;
    w      = {};
    n      = {f[1], f[0]};
    e_done = 1'b0;
    e_err  = 1'b0;
    if (n > (1 << ADDR_W)) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++)
      w.push_back({f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]});
    x = 8'h00;
    for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
    if (f[f.size()-1] == x) e_done = 1'b1;
    else                    e_err  = 1'b1;
  endtask

  function automatic logic [7:0] xor_all(input byte_q f);
    logic [7:0] x = 8'h00;
    foreach (f[i]) x ^= f[i];
    return x;
  endfunction

  function automatic byte_q make_frame(input int n, input bit corrupt);
    byte_q f;
    logic [15:0] n16;
    n16 = 16'(n);
    f.push_back(n16[7:0]);
    f.push_back(n16[15:8]);
    for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
    f.push_back(xor_all(f) ^ (corrupt ? 8'(1 + $urandom_range(254)) : 8'h00));
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit poke);
    int budget = 300;
    bit ok     = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge clk);
      budget--;
      start = poke && ($urandom_range(7) == 0);
      if ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
      end
      if (rx_valid && rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (!ok) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_hold", core_hold, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
  endtask

  task automatic wait_idle(input string tag);
    int budget = 20;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (busy) chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_frame(input byte_q f, input int gap_pct, input bit poke, input string tag);
    word_q w;
    bit    e_done, e_err;
    model(f, w, e_done, e_err);
    wq.delete();
    pulse_start();
    foreach (f[i]) send_byte(f[i], gap_pct, poke);
    wait_idle(tag);
    chk({tag, "_nwr"}, wq.size(), w.size());
    for (int i = 0; i < w.size() && i < wq.size(); i++) begin
      chk({tag, "_addr"}, wq[i].addr, i);
      chk({tag, "_data"}, wq[i].data, w[i]);
    end
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_hold"}, core_hold, !e_done);
  endtask

  initial begin
    byte_q basic, bad, f;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hold", core_hold, 1);
    rst = 1'b0;

    // Basic load with a correct checksum
    basic = '{8'h02, 8'h00, 8'h13, 8'h0F, 8'h10, 8'h01, 8'h93, 8'h00, 8'h50, 8'h00};
    basic.push_back(xor_all(basic));
    run_frame(basic, 0, 1'b0, "basic");
    if (wq.size() == 2) begin
      chk("basic_w0", wq[0].data, 32'h01100F13);
      chk("basic_w1", wq[1].data, 32'h00500093);
    end else chk("basic_count", wq.size(), 2);

    // Bad checksum: words still written, core stays held
    bad = basic;
    bad[bad.size()-1] ^= 8'h01;
    run_frame(bad, 0, 1'b0, "badcsum");

    // Zero-length frame
    f = '{8'h00, 8'h00, 8'h00};
    run_frame(f, 0, 1'b0, "zero");

    // Oversize length rejected right after LEN_HI
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h40, 0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    chk("ovs_err", err, 1);
    chk("ovs_ready", rx_ready, 0);
    @(negedge clk);
    chk("ovs_ready2", rx_ready, 0);
    chk("ovs_busy", busy, 0);
    chk("ovs_hold", core_hold, 1);
    chk("ovs_done", done, 0);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovs_nwr", wq.size(), 0);

    // Back-to-back bytes: one write every four cycles; then same frame gapped
    f = make_frame(6, 1'b0);
    run_frame(f, 0, 1'b0, "b2b");
    for (int i = 1; i < wq.size(); i++) chk("b2b_spacing", wq[i].t - wq[i-1].t, 4);
    run_frame(f, 50, 1'b1, "gapped");

    // Reset mid-frame after 6 data bytes
    pulse_start();
    f = make_frame(4, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(f[i], 0, 1'b0);
    @(negedge clk);
    wq.delete();
    rst      = 1'b1;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("mrst_ready", rx_ready, 0);
    chk("mrst_wen", mem_wen, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_data", mem_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_hold", core_hold, 1);
    rst      = 1'b0;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    chk("mrst_nwr", wq.size(), 0);
    chk("mrst_busy2", busy, 0);
    run_frame(make_frame(3, 1'b0), 20, 1'b0, "post_rst");

    // Random frames with random throttling and stray start pulses
    for (int k = 0; k < 8; k++)
      run_frame(make_frame($urandom_range(12), $urandom_range(3) == 0),
                $urandom_range(60), 1'b1, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
